// File: rtl/dcache_pkg.sv
// Shared data-cache definitions: line geometry, address split and memory responder states.
// The controller, tag array and line memory all import this so address fields agree.
package dcache_pkg;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned INDEX_W  = 5;
    localparam int unsigned TAG_W    = 22;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Single-port line storage: synchronous write, registered read.
// The read register is cleared whenever no read is issued, so it doubles as a zero-when-idle output.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned DEPTH  = 512,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem[idx_i];
        end else begin
            rdata_o <= '0;
        end
    end

endmodule

// File: rtl/dcache_line_mem.sv
// Fixed-latency memory responder for cache-line refills and write-backs.
// One request in flight; ack_o pulses for one cycle, carrying read data on reads.
module dcache_line_mem #(
    parameter int unsigned LINE_W  = dcache_pkg::LINE_W,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    import dcache_pkg::*;

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [7:0]  LAST_CNT = 8'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q;
    logic [IDX_W-1:0]  idx_in, idx_q, idx_sel;
    logic [LINE_W-1:0] wdata_q, wdata_sel;
    logic              write_q, write_sel;
    logic              accept, enter_done;
    logic              unused_addr_bits;

    assign idx_in           = addr_i[OFFSET_W +: IDX_W];
    assign unused_addr_bits = ^{addr_i[31:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};
    assign accept           = (state_q == IDLE) && enable_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_i) state_d = (LATENCY == 1) ? DONE : BUSY;
            BUSY:    if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=1 the array is accessed on the accepting edge, before the latch holds the request
    always_comb begin
        idx_sel    = idx_q;
        wdata_sel  = wdata_q;
        write_sel  = write_q;
        enter_done = (state_d == DONE) && !rst_i;
        if (state_q == IDLE) begin
            idx_sel   = idx_in;
            wdata_sel = data_i;
            write_sel = write_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_o   <= enter_done;
            if (accept) begin
                cnt_q <= 8'd1;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            idx_q   <= idx_in;
            wdata_q <= data_i;
            write_q <= write_i;
        end
    end

    dcache_line_array #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (enter_done && write_sel),
        .re_i    (enter_done && !write_sel),
        .idx_i   (idx_sel),
        .wdata_i (wdata_sel),
        .rdata_o (data_o)
    );

endmodule
